// File: rtl/pc_ret_stack_pkg.sv
// Shared defaults and the op-priority encoding for the program counter with
// its return-address stack.
package pc_ret_stack_pkg;

  localparam int              PC_WIDTH    = 16;
  localparam int              STACK_DEPTH = 8;
  localparam logic [15:0]     PC_RESET    = 16'h0000;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_DEC  = 3'd1,
    OP_INC  = 3'd2,
    OP_LOAD = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_CLR  = 3'd6
  } op_e;

  // One action per cycle: clr > ret > call > load > inc/dec; inc with dec holds.
  function automatic op_e decode_op(input logic clr, input logic ret,
                                    input logic call, input logic load,
                                    input logic inc, input logic dec);
    if (clr)               return OP_CLR;
    else if (ret)          return OP_RET;
    else if (call)         return OP_CALL;
    else if (load)         return OP_LOAD;
    else if (inc && !dec)  return OP_INC;
    else if (dec && !inc)  return OP_DEC;
    else                   return OP_HOLD;
  endfunction

endpackage

// File: rtl/pc_ret_stack_if.sv
// Command and status bundle of the program counter block.
interface pc_ret_stack_if
  import pc_ret_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) ();

  localparam int SPW = $clog2(DEPTH) + 1;

  // Commands are level-sampled on every rising edge; there is no ready, the
  // block retires exactly one (priority-selected) op per cycle.
  logic             clr;
  logic             inc;
  logic             dec;
  logic             load;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] addr;

  logic [WIDTH-1:0] pc;
  logic [SPW-1:0]   sp;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;
  op_e              op;

  modport master (
    output clr, inc, dec, load, call, ret, addr,
    input  pc, sp, full, empty, ovf, unf, op
  );

  modport slave (
    input  clr, inc, dec, load, call, ret, addr,
    output pc, sp, full, empty, ovf, unf, op
  );

endinterface

// File: rtl/pc_ret_stack_ret_stack.sv
// Return-address LIFO with occupancy count and sticky overflow/underflow flags.
module ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   sp_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  output logic                     unf_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d, sp_m1;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             do_push, do_pop;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;
  assign sp_m1   = sp_q - SPW'(1);
  assign dout_o  = mem_q[sp_m1[AW-1:0]];
  assign sp_o    = sp_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_i) begin
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (push_i && full_o) ovf_d = 1'b1;
      if (pop_i && empty_o) unf_d = 1'b1;
      if (do_push)          sp_d  = sp_q + SPW'(1);
      else if (do_pop)      sp_d  = sp_m1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage carries no reset so it can map onto LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[sp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pc_ret_stack.sv
// Program counter with inc/dec/jump and call/return via a small LIFO.
module pc_ret_stack
  import pc_ret_stack_pkg::*;
#(
  parameter int               WIDTH    = PC_WIDTH,
  parameter int               DEPTH    = STACK_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET)
) (
  input  logic           clk,
  input  logic           rst,
  pc_ret_stack_if.slave  bus
);

  localparam int SPW = $clog2(DEPTH) + 1;

  op_e              op;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, pc_dec, stk_top;
  logic [SPW-1:0]   stk_sp;
  logic             stk_full, stk_empty, stk_ovf, stk_unf;

  assign op     = decode_op(bus.clr, bus.ret, bus.call, bus.load, bus.inc, bus.dec);
  assign pc_inc = pc_q + WIDTH'(1);
  assign pc_dec = pc_q - WIDTH'(1);

  always_comb begin
    pc_d = pc_q;
    case (op)
      OP_CLR:           pc_d = RESET_PC;
      OP_RET:           if (!stk_empty) pc_d = stk_top;
      OP_CALL, OP_LOAD: pc_d = bus.addr;
      OP_INC:           pc_d = pc_inc;
      OP_DEC:           pc_d = pc_dec;
      default:          pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // A call while full still jumps; the stack itself drops the push and flags ovf.
  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (op == OP_CLR),
    .push_i  (op == OP_CALL),
    .pop_i   (op == OP_RET),
    .din_i   (pc_inc),
    .dout_o  (stk_top),
    .sp_o    (stk_sp),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .ovf_o   (stk_ovf),
    .unf_o   (stk_unf)
  );

  assign bus.pc    = pc_q;
  assign bus.sp    = stk_sp;
  assign bus.full  = stk_full;
  assign bus.empty = stk_empty;
  assign bus.ovf   = stk_ovf;
  assign bus.unf   = stk_unf;
  assign bus.op    = op;

endmodule

// File: tb/tb_pc_ret_stack.sv
// Bench for pc_ret_stack: hand-derived vector table, corner sequences and
// randomized ops checked against a queue-based reference model.
module tb_pc_ret_stack;

  localparam int DEPTH = 8;

  // Op bit order: {clr, ret, call, load, inc, dec}
  localparam logic [5:0] NOP  = 6'b000000;
  localparam logic [5:0] CLR  = 6'b100000;
  localparam logic [5:0] RET  = 6'b010000;
  localparam logic [5:0] CALL = 6'b001000;
  localparam logic [5:0] LOAD = 6'b000100;
  localparam logic [5:0] INC  = 6'b000010;
  localparam logic [5:0] DEC  = 6'b000001;

  typedef struct {
    logic [5:0]  ops;
    logic [15:0] addr;
    logic [15:0] exp_pc;
    logic [3:0]  exp_sp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] exp_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_ovf;
  logic        m_unf;

  pc_ret_stack_if bus ();

  pc_ret_stack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc  = 16'h0000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic [5:0] ops, input logic [15:0] a);
    logic [15:0] ret_addr;
    if (ops[5]) begin
      model_reset();
    end else if (ops[4]) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else                  m_unf = 1'b1;
    end else if (ops[3]) begin
      ret_addr = m_pc + 16'd1;
      if (m_stk.size() < DEPTH) m_stk.push_back(ret_addr);
      else                      m_ovf = 1'b1;
      m_pc = a;
    end else if (ops[2]) begin
      m_pc = a;
    end else if (ops[1] && !ops[0]) begin
      m_pc = m_pc + 16'd1;
    end else if (ops[0] && !ops[1]) begin
      m_pc = m_pc - 16'd1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [15:0] exp_pc;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_pc = exp_q.pop_front();
      check("pc",    32'(bus.pc),    32'(exp_pc));
    end
    check("sp",    32'(bus.sp),    32'(m_stk.size()));
    check("full",  32'(bus.full),  32'(m_stk.size() == DEPTH));
    check("empty", 32'(bus.empty), 32'(m_stk.size() == 0));
    check("ovf",   32'(bus.ovf),   32'(m_ovf));
    check("unf",   32'(bus.unf),   32'(m_unf));
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    {bus.clr, bus.ret, bus.call, bus.load, bus.inc, bus.dec} = NOP;
    bus.addr = 16'h0000;
  endtask

  task automatic do_op(input logic [5:0] ops, input logic [15:0] a);
    @(negedge clk);
    {bus.clr, bus.ret, bus.call, bus.load, bus.inc, bus.dec} = ops;
    bus.addr = a;
    model_step(ops, a);
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- test ----------------
  vec_t vecs[14];

  initial begin
    logic [15:0] ret_exp;
    logic [5:0]  rops;

    checks = 0;
    errors = 0;

    vecs[0]  = '{INC,        16'h0000, 16'h0001, 4'd0};
    vecs[1]  = '{INC,        16'h0000, 16'h0002, 4'd0};
    vecs[2]  = '{INC,        16'h0000, 16'h0003, 4'd0};
    vecs[3]  = '{LOAD,       16'hFFFE, 16'hFFFE, 4'd0};
    vecs[4]  = '{INC,        16'h0000, 16'hFFFF, 4'd0};
    vecs[5]  = '{INC,        16'h0000, 16'h0000, 4'd0};
    vecs[6]  = '{DEC,        16'h0000, 16'hFFFF, 4'd0};
    vecs[7]  = '{LOAD,       16'h0010, 16'h0010, 4'd0};
    vecs[8]  = '{CALL,       16'h0100, 16'h0100, 4'd1};
    vecs[9]  = '{CALL,       16'h0200, 16'h0200, 4'd2};
    vecs[10] = '{RET,        16'h0000, 16'h0101, 4'd1};
    vecs[11] = '{RET,        16'h0000, 16'h0011, 4'd0};
    vecs[12] = '{INC | DEC,  16'h0000, 16'h0011, 4'd0};
    vecs[13] = '{DEC,        16'h0000, 16'h0010, 4'd0};

    // Reset state
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc",    32'(bus.pc),    32'h0);
    check("rst_sp",    32'(bus.sp),    32'h0);
    check("rst_empty", 32'(bus.empty), 32'h1);
    check("rst_full",  32'(bus.full),  32'h0);
    check("rst_ovf",   32'(bus.ovf),   32'h0);
    check("rst_unf",   32'(bus.unf),   32'h0);
    rst = 1'b0;

    // Hand-derived vector table
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].ops, vecs[i].addr);
      check($sformatf("vec%0d_pc", i), 32'(bus.pc), 32'(vecs[i].exp_pc));
      check($sformatf("vec%0d_sp", i), 32'(bus.sp), 32'(vecs[i].exp_sp));
    end

    // Overflow: 9 calls into an 8-deep stack
    do_op(CLR, 16'h0000);
    for (int k = 1; k <= 9; k++) begin
      do_op(CALL, 16'(16'h1000 + k * 16'h10));
      if (k == 8) check("full_after_8", 32'(bus.full), 32'h1);
    end
    check("ovf_after_9", 32'(bus.ovf), 32'h1);
    check("sp_after_9",  32'(bus.sp),  32'd8);
    check("pc_after_9",  32'(bus.pc),  32'h1090);

    // Unwind: ret j returns to call (8-j)'s target + 1, last one to 0001
    for (int j = 1; j <= 8; j++) begin
      do_op(RET, 16'h0000);
      ret_exp = (j == 8) ? 16'h0001 : 16'(16'h1000 + (8 - j) * 16'h10 + 1);
      check($sformatf("unwind%0d_pc", j), 32'(bus.pc), 32'(ret_exp));
    end
    do_op(RET, 16'h0000);
    check("underflow_pc_hold", 32'(bus.pc),  32'h0001);
    check("underflow_unf",     32'(bus.unf), 32'h1);
    check("underflow_ovf_kept", 32'(bus.ovf), 32'h1);

    // Simultaneous ops
    do_op(CLR, 16'h0000);
    do_op(CALL, 16'h0300);
    do_op(RET | CALL | INC, 16'h0500);
    check("ret_wins_pc",  32'(bus.pc),  32'h0001);
    check("ret_wins_sp",  32'(bus.sp),  32'h0);
    check("ret_wins_ovf", 32'(bus.ovf), 32'h0);
    do_op(LOAD, 16'h0042);
    do_op(INC | DEC, 16'h0000);
    check("incdec_hold", 32'(bus.pc), 32'h0042);
    do_op(RET, 16'h0000);
    do_op(CLR | RET | CALL | INC, 16'h7777);
    check("clr_pc",  32'(bus.pc),  32'h0);
    check("clr_unf", 32'(bus.unf), 32'h0);
    check("clr_sp",  32'(bus.sp),  32'h0);

    // Asynchronous reset between edges after two calls
    do_op(CALL, 16'h0A00);
    do_op(CALL, 16'h0B00);
    drive_idle();
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc",    32'(bus.pc),    32'h0);
    check("async_rst_sp",    32'(bus.sp),    32'h0);
    check("async_rst_empty", 32'(bus.empty), 32'h1);
    #3 rst = 1'b0;
    model_reset();
    do_op(INC, 16'h0000);
    check("after_rst_inc", 32'(bus.pc), 32'h0001);
    do_op(RET, 16'h0000);
    check("after_rst_ret_unf", 32'(bus.unf), 32'h1);

    // Randomized ops against the model
    do_op(CLR, 16'h0000);
    for (int n = 0; n < 400; n++) begin
      rops[5] = ($urandom_range(0, 24) == 0);
      rops[4] = ($urandom_range(0, 3) == 0);
      rops[3] = ($urandom_range(0, 2) == 0);
      rops[2] = ($urandom_range(0, 5) == 0);
      rops[1] = 1'($urandom_range(0, 1));
      rops[0] = 1'($urandom_range(0, 1));
      do_op(rops, 16'($urandom()));
    end

    // ---------------- report ----------------
    drive_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_ret_stack.md
Name: pc_ret_stack

Overview:
- 16-bit program counter register for the Hack-style CPU datapath.
- Supports increment, decrement, jump, and call/return through a small return-address stack.
- Sits between the ALU/jump logic and instruction memory addressing.
- Consumes the +1 value as its increment path and adds the −1 path for decrement.

Parameters:
- WIDTH, 16, PC and stack-entry width in bits.
- DEPTH, 8, return-stack entries (power of 2, ≥2).
- RESET_PC, 16'h0000, PC value after reset or clear.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear: PC←RESET_PC, stack emptied, flags cleared.
- inc  in  1  PC←PC+1.
- dec  in  1  PC←PC−1.
- load  in  1  jump: PC←addr.
- call  in  1  jump to addr and push PC+1.
- ret  in  1  pop the stack top into PC.
- addr  in  WIDTH  jump/call target.
- pc  out  WIDTH  current PC, registered.
- sp  out  $clog2(DEPTH)+1  occupied stack entries (0..DEPTH).
- full  out  1  sp==DEPTH.
- empty  out  1  sp==0.
- ovf  out  1  sticky overflow: call attempted while full.
- unf  out  1  sticky underflow: ret attempted while empty.

Behaviour:
- Reset (rst=1, asynchronous):
  - pc=RESET_PC, sp=0, empty=1, full=0, ovf=0, unf=0.
  - Stack contents are don't-care.
  - Reset mid-operation abandons any pending op; no partial push or pop is visible after release.
- All updates happen on the rising clk edge; pc reflects an op one cycle after it is sampled.
- Priority, one action per cycle:
  - clr > ret > call > load > (inc/dec) > hold.
  - inc=1 with dec=1 (no higher op asserted) → hold.
- Arithmetic is modulo 2^WIDTH:
  - inc at 16'hFFFF → 16'h0000.
  - dec at 16'h0000 → 16'hFFFF.
  - No carry or borrow output.
- call, not full:
  - stack[sp]←PC+1 (wrapped), sp←sp+1, PC←addr.
- call, full:
  - PC←addr; push dropped; sp unchanged; ovf←1.
- ret, not empty:
  - PC←stack[sp−1], sp←sp−1.
- ret, empty:
  - PC holds; sp unchanged; unf←1.
- ret and call in the same cycle: ret wins; call is ignored (no push, no ovf).
- ovf and unf stay set until rst or clr.
- full and empty are combinational decodes of the registered sp, so they are effectively registered.
- Stack storage has no reset requirement; it may be implemented in flops or LUT RAM.

Decomposition:
- Shared package holds: WIDTH default, op-priority encoding constants (OP_CLR, OP_RET, OP_CALL, OP_LOAD, OP_INC, OP_DEC, OP_HOLD), and RESET_PC.
- One sub-module: ret_stack, a LIFO of DEPTH×WIDTH.
  - Inputs: push, pop, din.
  - Outputs: dout (top), sp, full, empty, ovf, unf.
  - Uses the same clk/rst.
- The top level contains the priority decoder, the +1/−1 adders and the PC register.

Test Plan:
- Reset then inc ×3 → pc 0000→0001→0002→0003; sp=0, empty=1.
- load addr=FFFE, then inc ×2 → pc FFFE→FFFF→0000 (wrap). Then dec → FFFF.
- At pc=0010: call addr=0100, then call addr=0200, then ret, then ret → pc 0100, 0200, 0101, 0011; sp 1,2,1,0.
- Overflow and underflow:
  - 9 calls with DEPTH=8 → full=1 after the 8th; 9th jumps but ovf=1, sp=8.
  - Then 8 rets unwind the correct addresses.
  - A further ret → pc holds, unf=1.
- Simultaneous ops:
  - ret+call+inc with sp=1 → pop wins, sp=0, no push.
  - inc+dec → pc unchanged.
  - clr with any op → pc=0000, flags cleared.
- Assert rst asynchronously between edges after 2 calls → pc=0000 and sp=0 immediately, before the next edge; normal ops resume after release.
